// File: rtl/neo_mbx_pkg.sv
// Shared types and constants for the sound-command mailbox between the 68K and the Z80.
package neo_mbx_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int DATA_W      = 8;

   typedef enum logic [1:0] {
      NMI_IDLE   = 2'd0,
      NMI_ASSERT = 2'd1,
      NMI_HELD   = 2'd2
   } nmi_state_t;

   // One-cycle strobe events after synchronisation and edge detection.
   typedef struct packed {
      logic sdw;
      logic sdrr;
      logic z80r;
      logic z80w;
      logic clr;
      logic nmi_en;
      logic nmi_dis;
   } mbx_events_t;

endpackage

// File: rtl/neo_strobe_sync.sv
// Synchroniser plus assertion-edge detector for one active-low strobe.
module neo_strobe_sync
   import neo_mbx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic strobe_n,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic [SYNC_STAGES:0]   fill_q;

   // fill_q marks when last_q holds a real post-reset sample, so a strobe held
   // low across reset cannot be mistaken for a fresh assertion.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         last_q <= 1'b1;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n};
         last_q <= sync_q[SYNC_STAGES-1];
         fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign fall_pulse = fill_q[SYNC_STAGES] & last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/neo_sound_mailbox.sv
// Sound mailbox: 68K->Z80 command latch, Z80->68K reply latch and Z80 NMI sequencing.
//
//   state      | meaning
//   NMI_IDLE   | no command awaiting acknowledge, NMI inactive
//   NMI_ASSERT | command awaiting acknowledge, NMI driven low
//   NMI_HELD   | command awaiting acknowledge, NMI masked until re-enabled
module neo_sound_mailbox
   import neo_mbx_pkg::*;
(
   input  logic              CLK_24M,
   input  logic              RESET,
   input  logic              nSDW,
   input  logic [DATA_W-1:0] M68K_DATA,
   input  logic              nSDRR,
   input  logic              nSDZ80R,
   input  logic              nSDZ80W,
   input  logic              nSDZ80CLR,
   input  logic              nNMIEN,
   input  logic              nNMIDIS,
   input  logic [DATA_W-1:0] SDD_IN,
   output logic [DATA_W-1:0] SDD_CMD,
   output logic [DATA_W-1:0] M68K_REPLY,
   output logic              nZ80NMI,
   output logic              CMD_PENDING,
   output logic              REPLY_VALID,
   output logic              OVERRUN
);

   mbx_events_t ev;

   neo_strobe_sync u_sync_sdw  (.clk(CLK_24M), .rst(RESET), .strobe_n(nSDW),      .fall_pulse(ev.sdw));
   neo_strobe_sync u_sync_sdrr (.clk(CLK_24M), .rst(RESET), .strobe_n(nSDRR),     .fall_pulse(ev.sdrr));
   neo_strobe_sync u_sync_z80r (.clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80R),   .fall_pulse(ev.z80r));
   neo_strobe_sync u_sync_z80w (.clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80W),   .fall_pulse(ev.z80w));
   neo_strobe_sync u_sync_clr  (.clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80CLR), .fall_pulse(ev.clr));
   neo_strobe_sync u_sync_en   (.clk(CLK_24M), .rst(RESET), .strobe_n(nNMIEN),    .fall_pulse(ev.nmi_en));
   neo_strobe_sync u_sync_dis  (.clk(CLK_24M), .rst(RESET), .strobe_n(nNMIDIS),   .fall_pulse(ev.nmi_dis));

   // Data follows the same stage count as the strobes, so the byte used is the
   // one present when the strobe was first sampled low.
   logic [DATA_W-1:0] cmd_dly   [SYNC_STAGES];
   logic [DATA_W-1:0] reply_dly [SYNC_STAGES];

   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            cmd_dly[i]   <= '0;
            reply_dly[i] <= '0;
         end
      end else begin
         cmd_dly[0]   <= M68K_DATA;
         reply_dly[0] <= SDD_IN;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            cmd_dly[i]   <= cmd_dly[i-1];
            reply_dly[i] <= reply_dly[i-1];
         end
      end
   end

   logic [DATA_W-1:0] cmd_q;
   logic [DATA_W-1:0] reply_q;
   logic              pending_q;
   logic              valid_q;
   logic              overrun_q;
   logic              nmi_en_q;
   logic              nmi_en_d;
   nmi_state_t        state_q;
   nmi_state_t        state_d;

   // A write arriving together with a Z80 read is treated as newer than the read.
   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         cmd_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else if (ev.sdw) begin
         cmd_q     <= cmd_dly[SYNC_STAGES-1];
         pending_q <= 1'b1;
         overrun_q <= (overrun_q | pending_q) & ~ev.z80r;
      end else if (ev.z80r) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         reply_q <= '0;
         valid_q <= 1'b0;
      end else if (ev.z80w) begin
         reply_q <= reply_dly[SYNC_STAGES-1];
         valid_q <= 1'b1;
      end else if (ev.sdrr) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         nmi_en_q <= 1'b0;
         state_q  <= NMI_IDLE;
      end else begin
         nmi_en_q <= nmi_en_d;
         state_q  <= state_d;
      end
   end

   always_comb begin
      nmi_en_d = nmi_en_q;
      if (ev.nmi_dis) begin
         nmi_en_d = 1'b0;
      end else if (ev.nmi_en) begin
         nmi_en_d = 1'b1;
      end

      state_d = state_q;
      unique case (state_q)
         NMI_IDLE: begin
            if (ev.sdw) begin
               state_d = nmi_en_d ? NMI_ASSERT : NMI_HELD;
            end
         end
         NMI_ASSERT: begin
            if (ev.sdw) begin
               state_d = NMI_ASSERT;
            end else if (ev.clr) begin
               state_d = NMI_IDLE;
            end else if (!nmi_en_d) begin
               state_d = NMI_HELD;
            end
         end
         NMI_HELD: begin
            if (ev.sdw) begin
               state_d = NMI_HELD;
            end else if (ev.clr) begin
               state_d = NMI_IDLE;
            end else if (nmi_en_d) begin
               state_d = NMI_ASSERT;
            end
         end
         default: state_d = NMI_IDLE;
      endcase
   end

   assign SDD_CMD     = cmd_q;
   assign M68K_REPLY  = reply_q;
   assign CMD_PENDING = pending_q;
   assign REPLY_VALID = valid_q;
   assign OVERRUN     = overrun_q;
   assign nZ80NMI     = (state_q != NMI_ASSERT);

endmodule
